// File: rtl/ms_board_pkg.sv
// Shared types for the minesweeper board engine: cell layout, command opcodes,
// controller FSM states and the row-major cell index helper.
package ms_board_pkg;

  localparam int CELL_W = 8;

  typedef enum logic [2:0] {
    ST_HIDDEN   = 3'd0,
    ST_REVEALED = 3'd1,
    ST_FLAG     = 3'd2,
    ST_BOMB     = 3'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_CLEAR  = 3'd0,
    OP_PLACE  = 3'd1,
    OP_COUNT  = 3'd2,
    OP_REVEAL = 3'd3,
    OP_FLAG   = 3'd4
  } op_t;

  typedef struct packed {
    logic [3:0] cnt;
    state_t     st;
    logic       bomb;
  } cell_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR_SCAN,
    S_CNT_SCAN,
    S_FLOOD_SCAN,
    S_RESP
  } fsm_t;

  function automatic int unsigned cell_idx(input int unsigned r, input int unsigned c,
                                           input int unsigned cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/ms_board_if.sv
// Command/response port of the board engine; master is the game-input FSM.
interface ms_board_if #(
  parameter int RW = 3,
  parameter int CW = 3
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [RW-1:0] cmd_row;
  logic [CW-1:0] cmd_col;
  logic          resp_valid;
  logic          resp_err;

  modport master (output cmd_valid, cmd_op, cmd_row, cmd_col,
                  input  cmd_ready, resp_valid, resp_err);
  modport slave  (input  cmd_valid, cmd_op, cmd_row, cmd_col,
                  output cmd_ready, resp_valid, resp_err);
endinterface

// File: rtl/ms_neigh_count.sv
// Combinational 3x3 neighbourhood inspector: bomb count around (row_i,col_i)
// and whether any in-range neighbour is a revealed zero-count cell.
module ms_neigh_count
  import ms_board_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic [ROWS*COLS*CELL_W-1:0] board_i,
  input  logic [$clog2(ROWS)-1:0]     row_i,
  input  logic [$clog2(COLS)-1:0]     col_i,
  output logic [3:0]                  cnt_o,
  output logic                        zero_nb_o
);

  localparam int BW = $clog2(ROWS * COLS * CELL_W);

  int    nr;
  int    nc;
  cell_t nb;

  always_comb begin
    cnt_o     = '0;
    zero_nb_o = 1'b0;
    nr        = 0;
    nc        = 0;
    nb        = '0;
    for (int unsigned k = 0; k < 9; k++) begin
      nr = int'(row_i) + int'(k / 3) - 1;
      nc = int'(col_i) + int'(k % 3) - 1;
      if (k != 4 && nr >= 0 && nr < ROWS && nc >= 0 && nc < COLS) begin
        nb = board_i[BW'(cell_idx(nr, nc, COLS) * CELL_W) +: CELL_W];
        if (nb.bomb) cnt_o = cnt_o + 4'd1;
        if (nb.st == ST_REVEALED && nb.cnt == 4'd0) zero_nb_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ms_board_ctrl.sv
// Minesweeper board store and command engine (ROWS x COLS cells).
// Define MS_BOARD_FLOOD_EN to build the zero-count flood reveal scan.
module ms_board_ctrl
  import ms_board_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  ms_board_if.slave                           bus,
  output logic                                busy,
  output logic                                game_over,
  output logic [$clog2(ROWS)+$clog2(COLS):0]  revealed_cnt,
  output logic [ROWS*COLS*CELL_W-1:0]         board_o
);

  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(COLS);
  localparam int N    = ROWS * COLS;
  localparam int IW   = $clog2(N);
  localparam int CNTW = RW + CW + 1;

  fsm_t            state_q, state_d;
  cell_t           cells_q [N];
  cell_t           cells_d [N];
  logic [RW-1:0]   scan_r_q, scan_r_d, nxt_r;
  logic [CW-1:0]   scan_c_q, scan_c_d, nxt_c;
  logic            err_q, err_d;
  logic            go_q, go_d;
  logic [CNTW-1:0] rcnt_q, rcnt_d;
`ifdef MS_BOARD_FLOOD_EN
  logic            chg_q, chg_d;
  logic            flip;
`endif

  logic [IW-1:0]   idx, tgt;
  logic            last, in_rng;
  cell_t           tc;
  logic [3:0]      nb_cnt;
  logic            nb_zero;

  ms_neigh_count #(.ROWS(ROWS), .COLS(COLS)) u_neigh (
    .board_i   (board_o),
    .row_i     (scan_r_q),
    .col_i     (scan_c_q),
    .cnt_o     (nb_cnt),
    .zero_nb_o (nb_zero)
  );

`ifndef MS_BOARD_FLOOD_EN
  logic unused_nb_zero;
  assign unused_nb_zero = nb_zero;
`endif

  always_comb begin
    board_o = '0;
    for (int unsigned i = 0; i < N; i++) board_o[i*CELL_W +: CELL_W] = cells_q[i];
  end

  assign idx    = IW'(cell_idx(scan_r_q, scan_c_q, COLS));
  assign tgt    = IW'(cell_idx(bus.cmd_row, bus.cmd_col, COLS));
  assign in_rng = (int'(bus.cmd_row) < ROWS) && (int'(bus.cmd_col) < COLS);
  assign last   = (scan_r_q == RW'(ROWS - 1)) && (scan_c_q == CW'(COLS - 1));
  assign nxt_c  = (scan_c_q == CW'(COLS - 1)) ? '0 : scan_c_q + CW'(1);
  assign nxt_r  = last ? '0 : (scan_c_q == CW'(COLS - 1)) ? scan_r_q + RW'(1) : scan_r_q;

  assign bus.cmd_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_err   = (state_q == S_RESP) && err_q;
  assign busy           = (state_q == S_CLR_SCAN) || (state_q == S_CNT_SCAN) ||
                          (state_q == S_FLOOD_SCAN);
  assign game_over      = go_q;
  assign revealed_cnt   = rcnt_q;

  always_comb begin
    state_d  = state_q;
    cells_d  = cells_q;
    scan_r_d = scan_r_q;
    scan_c_d = scan_c_q;
    err_d    = err_q;
    go_d     = go_q;
    rcnt_d   = rcnt_q;
`ifdef MS_BOARD_FLOOD_EN
    chg_d    = chg_q;
    flip     = 1'b0;
`endif
    tc       = cells_q[tgt];
    case (state_q)
      S_IDLE: if (bus.cmd_valid) begin
        err_d    = 1'b0;
        state_d  = S_RESP;
        scan_r_d = '0;
        scan_c_d = '0;
        case (op_t'(bus.cmd_op))
          OP_CLEAR: state_d = S_CLR_SCAN;
          OP_COUNT: if (go_q) err_d = 1'b1; else state_d = S_CNT_SCAN;
          OP_PLACE:
            if (!in_rng || go_q || tc.st != ST_HIDDEN) err_d = 1'b1;
            else cells_d[tgt].bomb = 1'b1;
          OP_FLAG:
            if (!in_rng || go_q) err_d = 1'b1;
            else if (tc.st == ST_HIDDEN) cells_d[tgt].st = ST_FLAG;
            else if (tc.st == ST_FLAG) cells_d[tgt].st = ST_HIDDEN;
            else err_d = 1'b1;
          OP_REVEAL:
            if (!in_rng || go_q || tc.st != ST_HIDDEN) err_d = 1'b1;
            else if (tc.bomb) begin
              cells_d[tgt].st = ST_BOMB;
              go_d            = 1'b1;
            end else begin
              cells_d[tgt].st = ST_REVEALED;
              rcnt_d          = rcnt_q + CNTW'(1);
`ifdef MS_BOARD_FLOOD_EN
              if (tc.cnt == 4'd0) begin
                state_d = S_FLOOD_SCAN;
                chg_d   = 1'b0;
              end
`endif
            end
          default: err_d = 1'b1;
        endcase
      end
      S_CLR_SCAN: begin
        cells_d[idx] = '0;
        scan_r_d     = nxt_r;
        scan_c_d     = nxt_c;
        if (last) begin
          go_d    = 1'b0;
          rcnt_d  = '0;
          state_d = S_RESP;
        end
      end
      S_CNT_SCAN: begin
        cells_d[idx].cnt = nb_cnt;
        scan_r_d         = nxt_r;
        scan_c_d         = nxt_c;
        if (last) state_d = S_RESP;
      end
`ifdef MS_BOARD_FLOOD_EN
      // Cells revealed earlier in a pass are already visible to later cells of
      // the same pass; another pass runs only if this one changed something.
      S_FLOOD_SCAN: begin
        flip = (cells_q[idx].st == ST_HIDDEN) && !cells_q[idx].bomb && nb_zero;
        if (flip) begin
          cells_d[idx].st = ST_REVEALED;
          rcnt_d          = rcnt_q + CNTW'(1);
        end
        scan_r_d = nxt_r;
        scan_c_d = nxt_c;
        if (last) begin
          chg_d = 1'b0;
          if (!(chg_q || flip)) state_d = S_RESP;
        end else if (flip) begin
          chg_d = 1'b1;
        end
      end
`endif
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      for (int unsigned i = 0; i < N; i++) cells_q[i] <= '0;
      scan_r_q <= '0;
      scan_c_q <= '0;
      err_q    <= 1'b0;
      go_q     <= 1'b0;
      rcnt_q   <= '0;
`ifdef MS_BOARD_FLOOD_EN
      chg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cells_q  <= cells_d;
      scan_r_q <= scan_r_d;
      scan_c_q <= scan_c_d;
      err_q    <= err_d;
      go_q     <= go_d;
      rcnt_q   <= rcnt_d;
`ifdef MS_BOARD_FLOOD_EN
      chg_q    <= chg_d;
`endif
    end
  end

endmodule

// File: tb/tb_ms_board_ctrl.sv
// Bench for ms_board_ctrl: 8x8 board against a grid-level reference model,
// plus a 5x6 board for out-of-range coordinates.
module tb_ms_board_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ms_board_if #(.RW(3), .CW(3)) b8 ();
  ms_board_if #(.RW(3), .CW(3)) bs ();

  logic         busy8, go8, busys, gos;
  logic [6:0]   rc8, rcs;
  logic [511:0] bd8;
  logic [239:0] bds;

  ms_board_ctrl #(.ROWS(8), .COLS(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b8), .busy(busy8), .game_over(go8),
    .revealed_cnt(rc8), .board_o(bd8));

  ms_board_ctrl #(.ROWS(5), .COLS(6)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(bs), .busy(busys), .game_over(gos),
    .revealed_cnt(rcs), .board_o(bds));

  int n_tests = 0;
  int n_fail  = 0;

  bit m_bomb [8][8];
  int m_st   [8][8];
  int m_cnt  [8][8];
  bit m_go;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic m_clear();
    foreach (m_st[r, c]) begin
      m_bomb[r][c] = 1'b0;
      m_st[r][c]   = 0;
      m_cnt[r][c]  = 0;
    end
    m_go = 1'b0;
  endtask

  function automatic logic [511:0] m_board();
    logic [511:0] b = '0;
    foreach (m_st[r, c]) b[(r*8+c)*8 +: 8] = {4'(m_cnt[r][c]), 3'(m_st[r][c]), m_bomb[r][c]};
    return b;
  endfunction

  function automatic int m_rev();
    int n = 0;
    foreach (m_st[r, c]) if (m_st[r][c] == 1) n++;
    return n;
  endfunction

  task automatic m_flood();
    int q[$];
    int p, rr, cc;
    foreach (m_st[r, c]) if (m_st[r][c] == 1 && m_cnt[r][c] == 0) q.push_back(r * 8 + c);
    while (q.size() > 0) begin
      p = q.pop_front();
      for (int dr = -1; dr <= 1; dr++)
        for (int dc = -1; dc <= 1; dc++) begin
          rr = p / 8 + dr;
          cc = p % 8 + dc;
          if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8 && m_st[rr][cc] == 0 && !m_bomb[rr][cc]) begin
            m_st[rr][cc] = 1;
            if (m_cnt[rr][cc] == 0) q.push_back(rr * 8 + cc);
          end
        end
    end
  endtask

  task automatic m_apply(input int op, input int r, input int c, output bit e);
    int n;
    e = 1'b0;
    if (op == 0) m_clear();
    else if (op == 2) begin
      if (m_go) e = 1'b1;
      else foreach (m_st[i, j]) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && i + dr >= 0 && i + dr < 8 && j + dc >= 0 && j + dc < 8)
              n += int'(m_bomb[i+dr][j+dc]);
        m_cnt[i][j] = n;
      end
    end else if (op == 1 || op == 3 || op == 4) begin
      if (r > 7 || c > 7 || m_go) e = 1'b1;
      else if (op == 1) begin
        if (m_st[r][c] != 0) e = 1'b1; else m_bomb[r][c] = 1'b1;
      end else if (op == 4) begin
        if (m_st[r][c] == 0) m_st[r][c] = 2;
        else if (m_st[r][c] == 2) m_st[r][c] = 0;
        else e = 1'b1;
      end else begin
        if (m_st[r][c] != 0) e = 1'b1;
        else if (m_bomb[r][c]) begin
          m_st[r][c] = 3;
          m_go       = 1'b1;
        end else begin
          m_st[r][c] = 1;
`ifdef MS_BOARD_FLOOD_EN
          if (m_cnt[r][c] == 0) m_flood();
`endif
        end
      end
    end else e = 1'b1;
  endtask

  task automatic issue(input bit sm, input int op, input int r, input int c,
                       output logic e, output int lat, output int bsy);
    int  g = 0;
    bit  seen = 1'b0;
    e   = 1'bx;
    lat = 0;
    bsy = 0;
    while (!(sm ? bs.cmd_ready : b8.cmd_ready) && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("cmd_ready_before_issue", sm ? bs.cmd_ready : b8.cmd_ready, 1);
    if (sm) begin
      bs.cmd_valid = 1'b1; bs.cmd_op = 3'(op); bs.cmd_row = 3'(r); bs.cmd_col = 3'(c);
    end else begin
      b8.cmd_valid = 1'b1; b8.cmd_op = 3'(op); b8.cmd_row = 3'(r); b8.cmd_col = 3'(c);
    end
    @(posedge clk);
    #1;
    bs.cmd_valid = 1'b0;
    b8.cmd_valid = 1'b0;
    while (!seen && lat < 3000) begin
      @(negedge clk);
      lat++;
      if (sm ? busys : busy8) bsy++;
      if (sm ? bs.resp_valid : b8.resp_valid) begin
        seen = 1'b1;
        e    = sm ? bs.resp_err : b8.resp_err;
      end
    end
    chk("resp_seen_within_bound", seen, 1);
  endtask

  task automatic run8(input int op, input int r, input int c, input int exp_lat,
                      output int lat, output int bsy);
    bit   me;
    logic e;
    m_apply(op, r, c, me);
    issue(1'b0, op, r, c, e, lat, bsy);
    chk($sformatf("resp_err op%0d (%0d,%0d)", op, r, c), e, me);
    chk($sformatf("board op%0d (%0d,%0d)", op, r, c), bd8, m_board());
    chk("game_over", go8, m_go);
    chk("revealed_cnt", rc8, m_rev());
    if (exp_lat >= 0) chk($sformatf("latency op%0d", op), lat, exp_lat);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat, bsy, op, r, c, el, pick;
    logic         e;
    logic [239:0] es;

    rst_n = 1'b0;
    b8.cmd_valid = 1'b0; b8.cmd_op = '0; b8.cmd_row = '0; b8.cmd_col = '0;
    bs.cmd_valid = 1'b0; bs.cmd_op = '0; bs.cmd_row = '0; bs.cmd_col = '0;
    m_clear();
    #2;
    chk("rst_board", bd8, '0);
    chk("rst_cmd_ready", b8.cmd_ready, 1);
    chk("rst_busy", busy8, 0);
    chk("rst_resp_valid", b8.resp_valid, 0);
    chk("rst_game_over", go8, 0);
    chk("rst_revealed_cnt", rc8, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run8(1, 0, 0, 1, lat, bsy);
    run8(1, 0, 1, 1, lat, bsy);
    run8(1, 1, 0, 1, lat, bsy);
    run8(2, 0, 0, 65, lat, bsy);
    chk("count_busy_cycles", bsy, 64);
    chk("cnt_cell_1_1", bd8[9*8 +: 8], 8'h30);
    chk("cnt_cell_0_0", bd8[0 +: 8], 8'h21);
    chk("cnt_cell_7_7", bd8[63*8 +: 8], 8'h00);

    run8(4, 2, 2, 1, lat, bsy);
    chk("flag_cell", bd8[18*8 +: 8], 8'h04);
    run8(3, 2, 2, 1, lat, bsy);
    chk("reveal_flag_err", b8.resp_err, 1);
    chk("reveal_flag_cell", bd8[18*8 +: 8], 8'h04);
    run8(4, 2, 2, 1, lat, bsy);
    chk("unflag_cell", bd8[18*8 +: 8], 8'h00);

    run8(3, 0, 0, 1, lat, bsy);
    chk("bomb_state", bd8[3:1], 3'd3);
    chk("bomb_game_over", go8, 1);
    run8(1, 5, 5, 1, lat, bsy);
    chk("place_after_over_err", b8.resp_err, 1);
    run8(0, 0, 0, 65, lat, bsy);
    chk("clear_busy_cycles", bsy, 64);
    chk("clear_game_over", go8, 0);

    es = '0;
    issue(1'b1, 3, 5, 0, e, lat, bsy);
    chk("small_row_oob_err", e, 1);
    chk("small_row_oob_lat", lat, 1);
    chk("small_row_oob_board", bds, es);
    issue(1'b1, 1, 4, 5, e, lat, bsy);
    es[29*8] = 1'b1;
    chk("small_place_err", e, 0);
    chk("small_place_board", bds, es);
    issue(1'b1, 3, 0, 6, e, lat, bsy);
    chk("small_col_oob_err", e, 1);
    chk("small_col_oob_board", bds, es);
    issue(1'b1, 4, 7, 7, e, lat, bsy);
    chk("small_both_oob_err", e, 1);
    chk("small_both_oob_board", bds, es);

    for (int i = 0; i < 160; i++) begin
      r    = int'($urandom_range(0, 7));
      c    = int'($urandom_range(0, 7));
      pick = int'($urandom_range(0, 99));
      if (pick < 15) op = 1;
      else if (pick < 45) op = 4;
      else if (pick < 80) op = 3;
      else if (pick < 92) op = 2;
      else op = 0;
      if (m_go && (op == 2 || $urandom_range(0, 3) == 0)) op = 0;
      el = (op == 0 || op == 2) ? 65 : 1;
`ifdef MS_BOARD_FLOOD_EN
      if (op == 3) el = -1;
`endif
      run8(op, r, c, el, lat, bsy);
    end

    run8(1, 3, 3, 1, lat, bsy);
    run8(4, 6, 6, 1, lat, bsy);
    while (!b8.cmd_ready) @(negedge clk);
    b8.cmd_valid = 1'b1;
    b8.cmd_op    = 3'd0;
    @(posedge clk);
    #1;
    b8.cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_clear_busy", busy8, 1);
    rst_n = 1'b0;
    #1;
    m_clear();
    chk("midscan_rst_board", bd8, '0);
    chk("midscan_rst_ready", b8.cmd_ready, 1);
    chk("midscan_rst_busy", busy8, 0);
    chk("midscan_rst_revealed", rc8, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run8(1, 0, 0, 1, lat, bsy);
    run8(2, 0, 0, 65, lat, bsy);
    run8(3, 7, 7, -1, lat, bsy);
`ifdef MS_BOARD_FLOOD_EN
    chk("flood_revealed_cnt", rc8, 63);
`else
    chk("single_reveal_cnt", rc8, 1);
    chk("single_reveal_cell", bd8[63*8 +: 8], 8'h02);
`endif
    chk("bomb_stays_hidden", bd8[3:1], 3'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
